tick_scheduler: RTL and testbench



---
 rtl/tick_scheduler.sv | 119 +++++++++++
 tb/tb_tick_scheduler.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/tick_scheduler.sv
// Shared free-running cycle counter with NUM_CH programmable one-cycle clock-enable ticks.
// Optional one-shot channels are enabled by defining TICK_SCHED_ONESHOT_EN.
module tick_scheduler #(
  parameter int NUM_CH = 4,
  parameter int CHW    = 2,
  parameter int PW     = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CHW-1:0]    cfg_ch,
  input  logic [PW-1:0]     cfg_period,
  input  logic              cfg_en,
`ifdef TICK_SCHED_ONESHOT_EN
  input  logic              cfg_oneshot,
`endif
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] active,
  output logic [31:0]       div_res
);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_APPLY = 1'b1;

  logic [0:0]     r_state;
  logic [CHW-1:0] r_ch;
  logic [PW-1:0]  r_period;
  logic           r_en;
  logic           r_os;
  logic [31:0]    r_div_res;
  logic           w_xfer;
  logic           w_os_in;

`ifdef TICK_SCHED_ONESHOT_EN
  assign w_os_in = cfg_oneshot;
`else
  assign w_os_in = 1'b0;
`endif

  assign cfg_ready = (r_state == S_IDLE);
  assign w_xfer    = cfg_valid & cfg_ready;
  assign div_res   = r_div_res;

  // Config port: accept in IDLE, write the latched request to its channel in APPLY.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_ch      <= '0;
      r_period  <= '0;
      r_en      <= 1'b0;
      r_os      <= 1'b0;
      r_div_res <= '0;
    end else begin
      r_div_res <= r_div_res + 32'd1;
      case (r_state)
        S_IDLE: begin
          if (w_xfer) begin
            r_ch     <= cfg_ch;
            r_period <= cfg_period;
            r_en     <= cfg_en;
            r_os     <= w_os_in;
            r_state  <= S_APPLY;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    localparam logic [CHW-1:0] IDX = CHW'(g);

    logic [PW-1:0] r_per;
    logic [PW-1:0] r_cnt;
    logic          r_tick;
    logic          r_active;
    logic          r_oneshot;
    logic          w_apply;

    // Out-of-range channel numbers never match any IDX, so they change nothing.
    assign w_apply   = (r_state == S_APPLY) && (r_ch == IDX);
    assign tick[g]   = r_tick;
    assign active[g] = r_active;

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        r_per     <= '0;
        r_cnt     <= '0;
        r_tick    <= 1'b0;
        r_active  <= 1'b0;
        r_oneshot <= 1'b0;
      end else if (w_apply) begin
        r_tick <= 1'b0;
        if (r_en && (r_period != '0)) begin
          r_per     <= r_period;
          r_cnt     <= r_period - PW'(1);
          r_active  <= 1'b1;
          r_oneshot <= r_os;
        end else begin
          r_cnt    <= '0;
          r_active <= 1'b0;
        end
      end else if (r_active) begin
        if (r_cnt == '0) begin
          r_tick <= 1'b1;
          r_cnt  <= r_per - PW'(1);
          if (r_oneshot) r_active <= 1'b0;
        end else begin
          r_tick <= 1'b0;
          r_cnt  <= r_cnt - PW'(1);
        end
      end else begin
        r_tick <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_tick_scheduler.sv
// Scoreboard bench for tick_scheduler: a per-channel reference model predicts each cycle's outputs.
module tb_tick_scheduler;
  localparam int NCH = 3;
  localparam int CHW = 2;
  localparam int PW  = 16;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           cfg_valid = 1'b0;
  logic           cfg_en = 1'b0;
  logic           cfg_oneshot = 1'b0;
  logic [CHW-1:0] cfg_ch = '0;
  logic [PW-1:0]  cfg_period = '0;
  logic           cfg_ready;
  logic [NCH-1:0] tick;
  logic [NCH-1:0] active;
  logic [31:0]    div_res;

  always #5 clk = ~clk;

  tick_scheduler #(.NUM_CH(NCH), .CHW(CHW), .PW(PW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_ch     (cfg_ch),
    .cfg_period (cfg_period),
    .cfg_en     (cfg_en),
`ifdef TICK_SCHED_ONESHOT_EN
    .cfg_oneshot(cfg_oneshot),
`endif
    .tick       (tick),
    .active     (active),
    .div_res    (div_res)
  );

  typedef struct packed {
    logic [NCH-1:0] tick;
    logic [NCH-1:0] active;
    logic           ready;
    logic [31:0]    div;
  } exp_t;

  exp_t q[$];
  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: each channel remembers the edge its config took effect and its period.
  int          e = 0;
  bit          rst_seen = 0;
  bit          m_en[NCH];
  bit          m_os[NCH];
  int          m_per[NCH];
  int          m_a[NCH];
  bit          m_ready = 1;
  bit          m_pend = 0;
  int          p_ch, p_per;
  bit          p_en, p_os;
  logic [31:0] div_base = '0;
  bit          force_now = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s actual=%h expected=%h edge=%0d", name, act, exp, e);
    end
  endtask

  task automatic model_update();
    if (!rst_n) begin
      for (int i = 0; i < NCH; i++) m_en[i] = 0;
      m_ready  = 1;
      m_pend   = 0;
      div_base = 32'(e);
      rst_seen = 1;
    end else if (m_pend) begin
      if (p_ch < NCH) begin
        if (p_en && p_per != 0) begin
          m_en[p_ch]  = 1;
          m_per[p_ch] = p_per;
          m_a[p_ch]   = e;
          m_os[p_ch]  = p_os;
        end else begin
          m_en[p_ch] = 0;
        end
      end
      m_pend  = 0;
      m_ready = 1;
    end else if (cfg_valid && m_ready) begin
      m_pend  = 1;
      m_ready = 0;
      p_ch    = int'(cfg_ch);
      p_per   = int'(cfg_period);
      p_en    = cfg_en;
      p_os    = cfg_oneshot;
`ifndef TICK_SCHED_ONESHOT_EN
      p_os    = 0;
`endif
    end
  endtask

  task automatic step();
    exp_t x;
    int   d;
    bit   forced;
    forced = 0;
    @(posedge clk);
    #1;
    e++;
    model_update();
    if (force_now && rst_seen) begin
      force dut.r_div_res = 32'hFFFF_FFFF;
      div_base  = 32'(e) + 32'd1;
      force_now = 0;
      forced    = 1;
    end
    if (rst_seen) begin
      x.ready  = m_ready;
      x.div    = 32'(e) - div_base;
      x.tick   = '0;
      x.active = '0;
      for (int i = 0; i < NCH; i++) begin
        if (m_en[i]) begin
          d = e - m_a[i];
          x.tick[i]   = (d > 0) && (d % m_per[i] == 0) && (!m_os[i] || d == m_per[i]);
          x.active[i] = !m_os[i] || (d < m_per[i]);
        end
      end
      q.push_back(x);
    end
    if (forced) begin
      #2;
      release dut.r_div_res;
    end
  endtask

  task automatic cfg(input int ch, input int p, input bit en, input bit os);
    bit acc;
    cfg_ch      = CHW'(ch);
    cfg_period  = PW'(p);
    cfg_en      = en;
    cfg_oneshot = os;
    cfg_valid   = 1'b1;
    for (int k = 0; k < 4; k++) begin
      acc = m_ready && rst_n;
      step();
      if (acc) break;
    end
    cfg_valid = 1'b0;
  endtask

  initial begin : monitor
    exp_t x;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        x = q.pop_front();
        chk("tick",      32'(tick),      32'(x.tick));
        chk("active",    32'(active),    32'(x.active));
        chk("cfg_ready", 32'(cfg_ready), 32'(x.ready));
        chk("div_res",   div_res,        x.div);
      end
    end
  end

  initial begin : driver
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    repeat (10) step();

    cfg(0, 4, 1, 0);
    repeat (45) step();

    cfg(1, 1, 1, 0);
    cfg(2, 3, 1, 0);
    repeat (10) step();
    cfg(1, 0, 0, 0);
    repeat (12) step();

    cfg(3, 5, 1, 0);
    repeat (6) step();
    cfg(2, 0, 1, 0);
    repeat (6) step();

    cfg(0, 2, 1, 0);
    repeat (5) step();
    cfg_valid  = 1'b1;
    cfg_ch     = 2'd1;
    cfg_period = 16'd3;
    cfg_en     = 1'b1;
    rst_n      = 1'b0;
    step();
    rst_n      = 1'b1;
    cfg_valid  = 1'b0;
    repeat (5) step();

    force_now = 1;
    step();
    repeat (3) step();

`ifdef TICK_SCHED_ONESHOT_EN
    cfg(0, 6, 1, 1);
    repeat (20) step();
`endif

    repeat (600) begin
      cfg_valid   = ($urandom_range(0, 3) == 0);
      cfg_ch      = CHW'($urandom_range(0, 3));
      cfg_period  = ($urandom_range(0, 7) == 0) ? '0 : PW'($urandom_range(1, 9));
      cfg_en      = ($urandom_range(0, 4) != 0);
      cfg_oneshot = 1'($urandom_range(0, 1));
      rst_n       = ($urandom_range(0, 199) != 0);
      step();
    end
    rst_n     = 1'b1;
    cfg_valid = 1'b0;
    repeat (3) step();

    @(negedge clk);
    #1;
    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
